// File: rtl/bitstream_reader.sv
// bitstream_reader: streams a word range of the bitstream buffer out over AXI-Stream.
// Define BITSWAP_EN to reverse bit order within each byte (ICAP ordering for raw .bin).
module bitstream_reader #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              icap_err,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              buf_en,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [31:0]       buf_rdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tkeep,
    output logic              m_axis_tlast
);
    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, issued_q, sent_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [31:0]       mem [4];
    logic [31:0]       wdata;
    logic [1:0]        rd_ptr, wr_ptr;
    logic [2:0]        fifo_cnt, inflight;
    logic [1:0]        flush_q;
    logic              done_q, err_q;
    logic              pop, push, keep, abort;
    logic              is_last, credit_ok, issue, flush_end;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 3'(vld_q[i]);
        end
    end

`ifdef BITSWAP_EN
    always_comb begin
        wdata = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                wdata[8*b+i] = buf_rdata[8*b+7-i];
            end
        end
    end
`else
    assign wdata = buf_rdata;
`endif

    assign m_axis_tvalid = fifo_cnt != '0;
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign m_axis_tkeep  = 4'hF;
    assign is_last       = sent_q == cnt_q - CW'(1);
    assign m_axis_tlast  = m_axis_tvalid && is_last;

    assign pop   = m_axis_tvalid && m_axis_tready;
    assign keep  = m_axis_tvalid && !m_axis_tready;
    assign push  = vld_q[RD_LAT-1];
    assign abort = icap_err && (state_q == READ || state_q == DRAIN);

    // Every outstanding read owns a FIFO slot before it is issued
    assign credit_ok = (fifo_cnt + inflight) < 3'd4;
    assign issue     = state_q == READ && issued_q != cnt_q
                       && credit_ok && !icap_err;
    assign flush_end = flush_q == 2'(RD_LAT - 1) && !keep;

    assign buf_en   = issue;
    assign buf_addr = addr_q;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && word_cnt != '0) state_d = READ;
            end
            READ: begin
                if (icap_err)                             state_d = FLUSH;
                else if (issue && issued_q + CW'(1) == cnt_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (icap_err)           state_d = FLUSH;
                else if (pop && is_last) state_d = IDLE;
            end
            FLUSH: begin
                if (flush_end) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            addr_q   <= '0;
            flush_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= (state_q == IDLE && start && word_cnt == '0)
                      || (state_q != IDLE && state_d == IDLE);
            if (state_q == IDLE && start) begin
                err_q <= 1'b0;
                if (word_cnt != '0) begin
                    cnt_q    <= word_cnt;
                    addr_q   <= base_addr;
                    issued_q <= '0;
                    sent_q   <= '0;
                end
            end
            if (issue) begin
                addr_q   <= addr_q + ADDR_W'(1);
                issued_q <= issued_q + CW'(1);
            end
            if (pop)   sent_q <= sent_q + CW'(1);
            if (abort) err_q  <= 1'b1;
            if (state_q != FLUSH)              flush_q <= '0;
            else if (flush_q != 2'(RD_LAT - 1)) flush_q <= flush_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (abort) begin
            // Keep only a presented-but-unaccepted head; drop everything else
            vld_q    <= '0;
            rd_ptr   <= rd_ptr + 2'(pop);
            wr_ptr   <= rd_ptr + 2'(m_axis_tvalid);
            fifo_cnt <= 3'(keep);
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !abort && push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: tb/tb_bitstream_reader.sv
// tb_bitstream_reader: randomized transfers checked against a queue-based
// model of the expected beat stream, address sequence and handshake timing.
module tb_bitstream_reader;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset, start, icap_err;
    logic [15:0] base_addr;
    logic [16:0] word_cnt;
    logic        busy, done, err, buf_en;
    logic [15:0] buf_addr;
    logic [31:0] buf_rdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;

    bitstream_reader #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .word_cnt(word_cnt),
        .icap_err(icap_err), .busy(busy), .done(done), .err(err),
        .buf_en(buf_en), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer with a two-cycle read latency
    logic [31:0] bmem [65536];
    logic [15:0] ra;
    always @(posedge clk) begin
        ra        <= buf_addr;
        buf_rdata <= bmem[ra];
    end

    logic [32:0] exp_q [$];
    logic [31:0] got_log [$];
    logic [15:0] exp_addr;
    int          issued, accepted, cur_cnt, first_tv, last_hs;
    bit          allow_issue, stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;
    int          tr_mode, pat;

    function automatic logic [31:0] ref_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef BITSWAP_EN
        for (int i = 0; i < 32; i++) r[i] = w[8*(i/8) + 7 - (i%8)];
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_model(input logic [15:0] base, input int cnt);
        exp_q.delete();
        got_log.delete();
        exp_addr    = base;
        issued      = 0;
        accepted    = 0;
        cur_cnt     = cnt;
        first_tv    = -1;
        last_hs     = -1;
        allow_issue = cnt > 0;
        for (int i = 0; i < cnt; i++)
            exp_q.push_back({i == cnt - 1, ref_word(bmem[16'(base + i)])});
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [16:0] cnt,
                               output int c0);
        @(posedge clk); #1;
        base_addr = base;
        word_cnt  = cnt;
        start     = 1'b1;
        c0        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", done, 1);
    endtask

    // tready patterns: 0 always, 1 repeating 1-0-0-1, 2 random, 3 manual
    initial begin
        pat = 0;
        forever begin
            @(posedge clk); #1;
            case (tr_mode)
                0: m_axis_tready = 1'b1;
                1: begin
                    m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
                    pat++;
                end
                2: m_axis_tready = $urandom_range(0, 99) < 70;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (buf_en) begin
                chk("issue_ok", allow_issue && issued < cur_cnt, 1);
                chk("buf_addr", buf_addr, exp_addr);
                chk("credit", (issued - accepted) < 4, 1);
                exp_addr = exp_addr + 16'd1;
                issued++;
            end
            if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
            if (stall_prev) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_data);
                chk("hold_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", exp_q.size(), 1);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, e[31:0]);
                    chk("tlast", m_axis_tlast, e[32]);
                    chk("tkeep", m_axis_tkeep, 4'hF);
                end
                got_log.push_back(m_axis_tdata);
                accepted++;
                last_hs = cyc;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic run_xfer(input logic [15:0] base, input int cnt,
                            input int mode, input bit inject);
        int c0, at;
        tr_mode = mode;
        load_model(base, cnt);
        pulse_start(base, 17'(cnt), c0);
        chk("busy_rise", busy, 1);
        chk("err_clr", err, 0);
        if (inject) begin
            for (int n = 0; n < 10 && cyc < c0 + 3; n++) @(negedge clk);
            base_addr = 16'($urandom);
            word_cnt  = 17'($urandom_range(1, 30));
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(at);
        chk("done_cyc", at, last_hs + 1);
        chk("busy_fall", busy, 0);
        chk("err_done", err, 0);
        chk("beats_left", exp_q.size(), 0);
        chk("issued", issued, cnt);
        if (mode == 0) begin
            chk("first_tv", first_tv, c0 + 2 + RD_LAT);
            chk("no_bubble", last_hs - first_tv, cnt - 1);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic run_zero();
        int c0;
        tr_mode = 0;
        load_model(16'($urandom), 0);
        pulse_start(base_addr, 17'd0, c0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_err", err, 0);
        @(posedge clk); #1;
        chk("zero_done_end", done, 0);
        chk("zero_busy2", busy, 0);
    endtask

    task automatic run_abort();
        int c0, at, n;
        logic [15:0] base;
        tr_mode = 3;
        m_axis_tready = 1'b1;
        base = 16'($urandom);
        load_model(base, 16);
        pulse_start(base, 17'd16, c0);
        n = 0;
        while (accepted < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach", accepted, 5);
        m_axis_tready = 1'b0;
        icap_err      = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        allow_issue = 1'b0;
        chk("abort_tv", m_axis_tvalid, 1);
        @(posedge clk); #1;
        icap_err = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_busy", busy, 1);
        end
        m_axis_tready = 1'b1;
        wait_done(at);
        chk("abort_done_cyc", at, last_hs + 1);
        chk("abort_err_done", err, 1);
        chk("abort_beats", accepted, 6);
        chk("abort_busy_fall", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("err_hold", err, 1);
        chk("abort_quiet", m_axis_tvalid, 0);
        tr_mode = 0;
    endtask

    task automatic run_reset();
        int c0;
        logic [15:0] base;
        tr_mode = 0;
        base = 16'($urandom);
        load_model(base, 8);
        pulse_start(base, 17'd8, c0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        allow_issue = 1'b0;
        issued      = 0;
        accepted    = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_buf_en", buf_en, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tkeep", m_axis_tkeep, 4'hF);
        repeat (8) begin
            @(negedge clk);
            chk("rst_no_tv", m_axis_tvalid, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        icap_err = 1'b0;
        m_axis_tready = 1'b0;
        base_addr = '0;
        word_cnt = '0;
        tr_mode = 3;
        stall_prev = 1'b0;
        allow_issue = 1'b0;
        issued = 0;
        accepted = 0;
        cur_cnt = 0;
        first_tv = -1;
        last_hs = -1;
        exp_addr = '0;
        for (int i = 0; i < 65536; i++) bmem[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_err", err, 0);
        chk("init_buf_en", buf_en, 0);
        chk("init_buf_addr", buf_addr, 0);
        chk("init_tvalid", m_axis_tvalid, 0);
        chk("init_tdata", m_axis_tdata, 0);
        chk("init_tlast", m_axis_tlast, 0);
        chk("init_tkeep", m_axis_tkeep, 4'hF);
        reset = 1'b0;

        for (int i = 16; i < 20; i++) bmem[i] = 32'(i);
        run_xfer(16'h0010, 4, 0, 1'b0);
        run_xfer(16'($urandom), 8, 1, 1'b0);
        run_zero();
        run_xfer(16'($urandom), 10, 0, 1'b1);
        run_abort();
        run_xfer(16'($urandom), 5, 0, 1'b0);

        bmem[16'hFFFF] = 32'h0102_0380;
        bmem[0]        = 32'h0000_000F;
        run_xfer(16'hFFFF, 2, 0, 1'b0);
        if (got_log.size() == 2) begin
`ifdef BITSWAP_EN
            chk("wrap_w0", got_log[0], 32'h8040_C001);
            chk("wrap_w1", got_log[1], 32'h0000_00F0);
`else
            chk("wrap_w0", got_log[0], 32'h0102_0380);
            chk("wrap_w1", got_log[1], 32'h0000_000F);
`endif
        end else begin
            chk("wrap_beats", got_log.size(), 2);
        end

        run_reset();

        for (int k = 0; k < 12; k++) begin
            logic [15:0] b;
            b = (k % 3 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                             : 16'($urandom);
            run_xfer(b, $urandom_range(1, 24), $urandom_range(1, 2),
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
